// File: rtl/alu_ctrl_issue.sv
// -----------------------------------------------------------------------------
// alu_ctrl_issue
//   Decodes RV32I instructions into a 4-bit ALU operation code and hands the
//   result to EX through a registered valid/ready stage. The output stage is a
//   2-entry skid buffer: M (main) drives ex_*, S (skid) catches the op accepted
//   while M is stalled. id_ready is a flop, so an EX stall never creates a
//   combinational path back into decode.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous squash of M and S (highest priority)
//   id_valid/ready  decode-side handshake; id_instr, id_pc are the payload
//   ex_valid/ready  execute-side handshake
//   ex_alu_ctrl     ALU operation code
//   ex_src_imm      1: operand B is the immediate, 0: rs2
//   ex_illegal      opcode/funct not supported (ex_alu_ctrl = ILLEGAL_CTRL)
//   ex_pc           PC tag of the op
// -----------------------------------------------------------------------------
module alu_ctrl_issue #(
  parameter int unsigned PC_W         = 32,
  parameter logic [3:0]  ILLEGAL_CTRL = 4'b0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     id_instr,
  input  logic [PC_W-1:0] id_pc,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [3:0]      ex_alu_ctrl,
  output logic            ex_src_imm,
  output logic            ex_illegal,
  output logic [PC_W-1:0] ex_pc
);

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]      alu_ctrl;
    logic            src_imm;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } entry_t;

  // Shared R/I-type funct3 mapping; alt selects SUB/SRA.
  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_instr_bits;

  assign opcode            = id_instr[6:0];
  assign f3                = id_instr[14:12];
  assign f7                = id_instr[31:25];
  assign unused_instr_bits = ^{id_instr[24:15], id_instr[11:7]};

  entry_t dec_entry;

  // Instruction decode; anything not matched below stays illegal.
  always_comb begin
    dec_entry          = '0;
    dec_entry.alu_ctrl = ILLEGAL_CTRL;
    dec_entry.src_imm  = 1'b0;
    dec_entry.illegal  = 1'b1;
    dec_entry.pc       = id_pc;
    case (opcode)
      OP_R: begin
        // funct7 0100000 only exists for SUB and SRA
        if ((f7 == F7_ZERO) ||
            ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
          dec_entry.alu_ctrl = arith_ctrl(f3, f7[5]);
          dec_entry.illegal  = 1'b0;
        end
      end
      OP_I: begin
        // ADDI carries immediate bits in [31:25], so bit 30 is not an opcode modifier
        dec_entry.alu_ctrl = (f3 == 3'b000) ? ALU_ADD : arith_ctrl(f3, f7[5]);
        dec_entry.src_imm  = 1'b1;
        dec_entry.illegal  = 1'b0;
      end
      OP_BRANCH: begin
        case (f3)
          3'b000, 3'b001: begin dec_entry.alu_ctrl = ALU_SUB;  dec_entry.illegal = 1'b0; end
          3'b100, 3'b101: begin dec_entry.alu_ctrl = ALU_SLT;  dec_entry.illegal = 1'b0; end
          3'b110, 3'b111: begin dec_entry.alu_ctrl = ALU_SLTU; dec_entry.illegal = 1'b0; end
          default: ;
        endcase
      end
      OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
        dec_entry.alu_ctrl = ALU_ADD;
        dec_entry.src_imm  = 1'b1;
        dec_entry.illegal  = 1'b0;
      end
      default: ;
    endcase
  end

  logic   m_valid_q, m_valid_d;
  logic   s_valid_q, s_valid_d;
  logic   id_ready_q, id_ready_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  logic   id_fire;

  assign id_fire = id_valid & id_ready_q;

  // Skid-buffer next state. S is only ever occupied while M is, so M is always the older op.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_d       = m_q;
    s_d       = s_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      // id_ready is low here, so the only possible move is S -> M
      if (ex_ready) begin
        m_d       = s_q;
        s_valid_d = 1'b0;
      end
    end else if (!m_valid_q || ex_ready) begin
      m_valid_d = id_fire;
      if (id_fire) begin
        m_d = dec_entry;
      end
    end else if (id_fire) begin
      s_valid_d = 1'b1;
      s_d       = dec_entry;
    end
    id_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      id_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      id_ready_q <= id_ready_d;
      m_q        <= m_d;
      s_q        <= s_d;
    end
  end

  assign id_ready    = id_ready_q;
  assign ex_valid    = m_valid_q;
  assign ex_alu_ctrl = m_q.alu_ctrl;
  assign ex_src_imm  = m_q.src_imm;
  assign ex_illegal  = m_q.illegal;
  assign ex_pc       = m_q.pc;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_issue
//   Directed checks of alu_ctrl_issue (reset, streaming decode, decode corner
//   cases, skid-buffer stall/ordering, flush, asynchronous reset mid-stream)
//   followed by a random valid/ready/flush run against a queue reference.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_issue;

  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b0001;
  localparam logic [3:0] AND_ = 4'b0010;
  localparam logic [3:0] OR_  = 4'b0011;
  localparam logic [3:0] SLL  = 4'b0100;
  localparam logic [3:0] SLT  = 4'b0101;
  localparam logic [3:0] XOR_ = 4'b0110;
  localparam logic [3:0] SRL  = 4'b0111;
  localparam logic [3:0] SLTU = 4'b1000;
  localparam logic [3:0] SRA  = 4'b1111;
  localparam logic [3:0] ILL  = 4'b0000;

  localparam logic [31:0] I_SUB  = 32'h40B50533;
  localparam logic [31:0] I_AND  = 32'h00B57533;
  localparam logic [31:0] I_SRAI = 32'h4025D593;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_alu_ctrl;
  logic        ex_src_imm;
  logic        ex_illegal;
  logic [31:0] ex_pc;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_ctrl_issue #(.PC_W(32), .ILLEGAL_CTRL(4'b0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_alu_ctrl (ex_alu_ctrl),
    .ex_src_imm  (ex_src_imm),
    .ex_illegal  (ex_illegal),
    .ex_pc       (ex_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_ex(input string tag, input logic v, input logic [3:0] ctrl,
                          input logic imm, input logic ill, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(ex_valid), 64'(v));
    check({tag, ".ctrl"},  64'(ex_alu_ctrl), 64'(ctrl));
    check({tag, ".imm"},   64'(ex_src_imm), 64'(imm));
    check({tag, ".ill"},   64'(ex_illegal), 64'(ill));
    check({tag, ".pc"},    64'(ex_pc), 64'(pc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    id_valid = v;
    id_instr = instr;
    id_pc    = pc;
  endtask

  // Reference decode: returns {illegal, src_imm, ctrl}
  function automatic logic [5:0] ref_decode(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] base;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    if      (f3 == 3'd0) base = ADD;
    else if (f3 == 3'd1) base = SLL;
    else if (f3 == 3'd2) base = SLT;
    else if (f3 == 3'd3) base = SLTU;
    else if (f3 == 3'd4) base = XOR_;
    else if (f3 == 3'd5) base = i[30] ? SRA : SRL;
    else if (f3 == 3'd6) base = OR_;
    else                 base = AND_;
    if (op == 7'h33) begin
      if (f7 == 7'h00)                                   return {2'b00, base};
      if (f7 == 7'h20 && f3 == 3'd0)                     return {2'b00, SUB};
      if (f7 == 7'h20 && f3 == 3'd5)                     return {2'b00, SRA};
      return {2'b10, ILL};
    end
    if (op == 7'h13) return {2'b01, base};
    if (op == 7'h63) begin
      if (f3 == 3'd0 || f3 == 3'd1) return {2'b00, SUB};
      if (f3 == 3'd4 || f3 == 3'd5) return {2'b00, SLT};
      if (f3 == 3'd6 || f3 == 3'd7) return {2'b00, SLTU};
      return {2'b10, ILL};
    end
    if (op == 7'h03 || op == 7'h23 || op == 7'h37 || op == 7'h17 ||
        op == 7'h6F || op == 7'h67) return {2'b01, ADD};
    return {2'b10, ILL};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [12];
    ops = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F, 7'h0B};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 11)];
    case ($urandom_range(0, 2))
      0:       w[31:25] = 7'h00;
      1:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  logic [37:0] exp_q [$];
  logic [37:0] exp_item;
  logic [37:0] cur_out;
  logic [37:0] prev_out;
  logic        prev_stall;
  logic        id_fire;
  logic        ex_fire;

  initial begin
    // Reset with id_valid high
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
    drive(1'b1, I_SUB, 32'h10);
    step(); step();
    check("rst.id_ready", 64'(id_ready), 64'd1);
    check_ex("rst", 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("post_rst.id_ready", 64'(id_ready), 64'd1);
    check_ex("post_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0);

    // Streaming with EX always ready: latency 1
    ex_ready = 1'b1;
    drive(1'b1, I_SUB, 32'h100);  step(); check_ex("stream_sub",  1'b1, SUB,  1'b0, 1'b0, 32'h100);
    drive(1'b1, I_AND, 32'h104);  step(); check_ex("stream_and",  1'b1, AND_, 1'b0, 1'b0, 32'h104);
    drive(1'b1, I_SRAI, 32'h108); step(); check_ex("stream_srai", 1'b1, SRA,  1'b1, 1'b0, 32'h108);
    drive(1'b0, 32'h0, 32'h0);    step(); check("stream_drain", 64'(ex_valid), 64'd0);

    // Decode corner cases
    drive(1'b1, 32'h00B56463, 32'h120); step(); check_ex("bltu",     1'b1, SLTU, 1'b0, 1'b0, 32'h120);
    drive(1'b1, 32'h00002003, 32'h124); step(); check_ex("lw",       1'b1, ADD,  1'b1, 1'b0, 32'h124);
    drive(1'b1, 32'h0000007F, 32'h128); step(); check_ex("bad_op",   1'b1, ILL,  1'b0, 1'b1, 32'h128);
    drive(1'b1, 32'h40050513, 32'h12C); step(); check_ex("addi_b30", 1'b1, ADD,  1'b1, 1'b0, 32'h12C);
    drive(1'b1, 32'h40B51533, 32'h130); step(); check_ex("sll_f7",   1'b1, ILL,  1'b0, 1'b1, 32'h130);
    drive(1'b1, 32'h00B52063, 32'h134); step(); check_ex("br_f3_2",  1'b1, ILL,  1'b0, 1'b1, 32'h134);
    drive(1'b1, 32'h00B546B3, 32'h138); step(); check_ex("xor",      1'b1, XOR_, 1'b0, 1'b0, 32'h138);
    drive(1'b0, 32'h0, 32'h0); step();

    // Stall: M then S fill, id_ready drops, then ordered drain
    ex_ready = 1'b0;
    drive(1'b1, I_SUB, 32'h200); step();
    check_ex("stall1", 1'b1, SUB, 1'b0, 1'b0, 32'h200);
    check("stall1.id_ready", 64'(id_ready), 64'd1);
    drive(1'b1, I_AND, 32'h204); step();
    check_ex("stall2", 1'b1, SUB, 1'b0, 1'b0, 32'h200);
    check("stall2.id_ready", 64'(id_ready), 64'd0);
    drive(1'b1, I_SRAI, 32'h208); step();
    check_ex("stall3", 1'b1, SUB, 1'b0, 1'b0, 32'h200);
    check("stall3.id_ready", 64'(id_ready), 64'd0);
    ex_ready = 1'b1; step();
    check_ex("drain1", 1'b1, AND_, 1'b0, 1'b0, 32'h204);
    check("drain1.id_ready", 64'(id_ready), 64'd1);
    step();
    check_ex("drain2", 1'b1, SRA, 1'b1, 1'b0, 32'h208);
    drive(1'b0, 32'h0, 32'h0); step();
    check("drain3.valid", 64'(ex_valid), 64'd0);

    // Flush with M and S full and a concurrent id transfer
    ex_ready = 1'b0;
    drive(1'b1, I_SUB, 32'h300); step();
    drive(1'b1, I_AND, 32'h304); step();
    check("pre_flush.id_ready", 64'(id_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, I_SRAI, 32'h308); step();
    check("flush.valid", 64'(ex_valid), 64'd0);
    check("flush.id_ready", 64'(id_ready), 64'd1);
    flush = 1'b0; ex_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0); step();
    check("post_flush1.valid", 64'(ex_valid), 64'd0);
    step();
    check("post_flush2.valid", 64'(ex_valid), 64'd0);

    // Asynchronous reset while holding an op
    ex_ready = 1'b0;
    drive(1'b1, I_AND, 32'h400); step();
    check_ex("pre_arst", 1'b1, AND_, 1'b0, 1'b0, 32'h400);
    #2 rst = 1'b1;
    #1;
    check("arst.id_ready", 64'(id_ready), 64'd1);
    check_ex("arst", 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Random valid/ready/flush against a queue reference
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      cur_out = {ex_illegal, ex_src_imm, ex_alu_ctrl, ex_pc};
      if (prev_stall) check("rnd_stable", 64'(cur_out), 64'(prev_out));
      id_valid = ($urandom_range(0, 99) < 60);
      ex_ready = ($urandom_range(0, 99) < 50);
      flush    = ($urandom_range(0, 99) < 3);
      id_instr = rand_instr();
      id_pc    = $urandom;
      #1;
      id_fire = id_valid & id_ready;
      ex_fire = ex_valid & ex_ready;
      if (ex_fire) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_out", 64'd1, 64'd0);
        end else begin
          exp_item = exp_q.pop_front();
          check("rnd_out", 64'(cur_out), 64'(exp_item));
        end
      end
      if (flush) exp_q.delete();
      else if (id_fire) exp_q.push_back({ref_decode(id_instr), id_pc});
      prev_stall = ex_valid & ~ex_ready & ~flush;
      prev_out   = cur_out;
      step();
      check("rnd_valid", 64'(ex_valid), 64'(exp_q.size() != 0));
      check("rnd_ready", 64'(id_ready), 64'(exp_q.size() < 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
